// File: rtl/bullet_ctrl.sv
// bullet_ctrl: owns MAX_B bullet slots (fire handshake, per-frame movement, hit retire)
// and renders them through a 2-stage sprite ROM lookup pipeline.
module bullet_ctrl #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int MAX_B = 4,
    parameter int SPEED = 4,
    parameter int DIR   = 0,
    localparam int IW   = $clog2(MAX_B)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             fire_req,
    input  logic [9:0]       fire_x,
    input  logic [9:0]       fire_y,
    output logic             fire_ack,
    output logic             fire_drop,
    input  logic             hit,
    input  logic [IW-1:0]    hit_idx,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    output logic [2:0]       spr_x,
    output logic [2:0]       spr_y,
    output logic             spr_en,
    input  logic             spr_data,
    output logic             pix_on,
    output logic [IW-1:0]    pix_idx,
    output logic [MAX_B-1:0] active_mask
);
    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;
    state_t state, state_nx;
    logic [MAX_B-1:0] active;
    logic [9:0] bx [MAX_B];
    logic [9:0] by [MAX_B];
    logic [10:0] ny [MAX_B];
    logic [10:0] dx [MAX_B];
    logic [10:0] dy [MAX_B];
    logic [MAX_B-1:0] gone;
    logic [IW-1:0] sel, sel_nx, m_idx, spr_idx;
    logic found, found_nx, m_en;
    logic [9:0] lx, ly;
    logic [2:0] m_x, m_y;

    assign fire_ack    = state == ISSUE && found;
    assign fire_drop   = state == ISSUE && !found;
    assign active_mask = active;

    // a slot being hit this cycle is never handed out, even if already free
    always_comb begin
        state_nx = state == IDLE ? (fire_req ? ISSUE : IDLE) : state == ISSUE ? HOLD : IDLE;
        found_nx = 1'b0;
        sel_nx   = '0;
        for (int i = MAX_B - 1; i >= 0; i--)
            if (!active[i] && !(hit && hit_idx == IW'(i))) begin
                found_nx = 1'b1;
                sel_nx   = IW'(i);
            end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sel   <= '0;
            found <= 1'b0;
            lx    <= '0;
            ly    <= '0;
        end else if (state == IDLE && fire_req) begin
            sel   <= sel_nx;
            found <= found_nx;
            lx    <= fire_x > 10'(H_RES - 6) ? 10'(H_RES - 6) : fire_x;
            ly    <= fire_y > 10'(V_RES - 6) ? 10'(V_RES - 6) : fire_y;
        end

    // 11-bit move result: bit 10 flags an upward underflow
    always_comb begin
        for (int i = 0; i < MAX_B; i++) begin
            ny[i]   = DIR != 0 ? {1'b0, by[i]} + 11'(SPEED) : {1'b0, by[i]} - 11'(SPEED);
            gone[i] = DIR != 0 ? ny[i] > 11'(V_RES - 6) : ny[i][10];
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            active <= '0;
            for (int i = 0; i < MAX_B; i++) begin
                bx[i] <= '0;
                by[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_B; i++)
                if (fire_ack && sel == IW'(i)) begin
                    active[i] <= 1'b1;
                    bx[i]     <= lx;
                    by[i]     <= ly;
                end else if (hit && hit_idx == IW'(i)) begin
                    active[i] <= 1'b0;
                end else if (frame_tick && active[i]) begin
                    active[i] <= !gone[i];
                    by[i]     <= ny[i][9:0];
                end
        end

    // a negative offset wraps to >= 1024, so one unsigned compare covers both bounds
    always_comb begin
        m_en  = 1'b0;
        m_x   = '0;
        m_y   = '0;
        m_idx = '0;
        for (int i = MAX_B - 1; i >= 0; i--) begin
            dx[i] = {1'b0, hcnt} - {1'b0, bx[i]};
            dy[i] = {1'b0, vcnt} - {1'b0, by[i]};
            if (active[i] && dx[i] < 11'd6 && dy[i] < 11'd6) begin
                m_en  = 1'b1;
                m_x   = dx[i][2:0];
                m_y   = dy[i][2:0];
                m_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            spr_en  <= 1'b0;
            spr_x   <= '0;
            spr_y   <= '0;
            spr_idx <= '0;
            pix_on  <= 1'b0;
            pix_idx <= '0;
        end else begin
            spr_en  <= m_en;
            spr_x   <= m_x;
            spr_y   <= m_y;
            spr_idx <= m_idx;
            pix_on  <= spr_en & spr_data;
            pix_idx <= spr_idx;
        end
endmodule
